// File: rtl/cmd_sched_pkg.sv
// Shared types and constants for the command scheduler: word width, arbitration
// source encoding, watchdog states and stall-timer terminal values.
package cmd_sched_pkg;

    localparam int CMD_W = 16;
    localparam int TMR_W = 22;

    // Terminal timer values: stall fires on the edge after the timer holds this value,
    // i.e. 2^12 or 2^22 cycles after the watchdog starts timing.
    localparam logic [TMR_W-1:0] STALL_FAST = 22'd4095;
    localparam logic [TMR_W-1:0] STALL_SLOW = 22'h3F_FFFF;

    typedef enum logic {SRC_UART = 1'b0, SRC_AUX = 1'b1} src_t;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STALLED = 2'd2} wd_state_t;

endpackage

// File: rtl/cmd_sched_if.sv
// Bundle of the source handshakes, the consumer handshake and status seen by cmd_sched.
// slave is the scheduler's view, master is the surrounding system's view.
interface cmd_sched_if #(
    parameter int DEPTH = 4
) ();
    import cmd_sched_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0] uart_cmd;
    logic             uart_rdy;
    logic             uart_clr;
    logic [CMD_W-1:0] aux_cmd;
    logic             aux_vld;
    logic             aux_ack;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             stall;

    modport slave (
        input  uart_cmd, uart_rdy, aux_cmd, aux_vld, clr_cmd_rdy, flush,
        output uart_clr, aux_ack, cmd, cmd_rdy, count, full, stall
    );

    modport master (
        output uart_cmd, uart_rdy, aux_cmd, aux_vld, clr_cmd_rdy, flush,
        input  uart_clr, aux_ack, cmd, cmd_rdy, count, full, stall
    );

endinterface

// File: rtl/cmd_fifo.sv
// Register-array FIFO with separate occupancy count; flush beats push and pop.
// Head word is read combinationally from the registered array.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// Round-robin arbiter of UART and auxiliary command sources into a FIFO, presenting
// the head with a cmd/cmd_rdy/clr_cmd_rdy handshake, plus a consumer-stall watchdog.
module cmd_sched
    import cmd_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit FAST_SIM = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    cmd_sched_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TMR_W-1:0] STALL_LIM = FAST_SIM ? STALL_FAST : STALL_SLOW;

    src_t             last_q, last_d;
    logic             uart_clr_q, aux_ack_q;
    logic             req_u, req_a, space;
    logic             grant_u, grant_a, push, pop, fifo_empties;
    logic [CMD_W-1:0] push_word, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    wd_state_t        wd_state_q;
    logic [TMR_W-1:0] timer_q;
    logic             stall_q;

    // Request masking, round-robin grant and push/pop strobes.
    always_comb begin
        req_u   = bus.uart_rdy & ~uart_clr_q;
        req_a   = bus.aux_vld & ~aux_ack_q;
        space   = ~fifo_full | bus.clr_cmd_rdy;
        grant_u = 1'b0;
        grant_a = 1'b0;
        if (~rst & ~bus.flush & space) begin
            if (req_u & req_a) begin
                if (last_q == SRC_UART) begin
                    grant_a = 1'b1;
                end else begin
                    grant_u = 1'b1;
                end
            end else begin
                grant_u = req_u;
                grant_a = req_a;
            end
        end else begin
            grant_u = 1'b0;
            grant_a = 1'b0;
        end
        if (grant_u) begin
            last_d = SRC_UART;
        end else if (grant_a) begin
            last_d = SRC_AUX;
        end else begin
            last_d = last_q;
        end
        push         = grant_u | grant_a;
        push_word    = grant_u ? bus.uart_cmd : bus.aux_cmd;
        pop          = bus.clr_cmd_rdy & ~fifo_empty;
        fifo_empties = (fifo_count == CNT_W'(1)) & ~push;
    end

    // Last-grant memory and one-cycle echoes of the accept pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= SRC_AUX;
            uart_clr_q <= 1'b0;
            aux_ack_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            uart_clr_q <= grant_u;
            aux_ack_q  <= grant_a;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .wdata (push_word),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stall watchdog: times how long the head waits without being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_state_q <= IDLE;
            timer_q    <= '0;
            stall_q    <= 1'b0;
        end else if (bus.flush) begin
            wd_state_q <= IDLE;
            timer_q    <= '0;
            stall_q    <= 1'b0;
        end else begin
            case (wd_state_q)
                IDLE: begin
                    if (~fifo_empty) begin
                        wd_state_q <= WAIT;
                        timer_q    <= '0;
                    end
                end
                WAIT: begin
                    if (pop) begin
                        wd_state_q <= fifo_empties ? IDLE : WAIT;
                        timer_q    <= '0;
                    end else if (timer_q == STALL_LIM) begin
                        wd_state_q <= STALLED;
                        stall_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                STALLED: begin
                    if (pop) begin
                        wd_state_q <= WAIT;
                        timer_q    <= '0;
                    end
                end
                default: begin
                    wd_state_q <= IDLE;
                    timer_q    <= '0;
                end
            endcase
        end
    end

    assign bus.uart_clr = grant_u;
    assign bus.aux_ack  = grant_a;
    assign bus.cmd      = head;
    assign bus.cmd_rdy  = ~fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.full     = fifo_full;
    assign bus.stall    = stall_q;

endmodule

// File: tb/tb_cmd_sched.sv
// Scenario bench for cmd_sched: expected words queue on grant, compare on pop.
module tb_cmd_sched;
    import cmd_sched_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [CMD_W-1:0] sb[$];
    logic [CMD_W-1:0] exp_w;

    cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    cmd_sched #(.DEPTH(DEPTH), .FAST_SIM(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push_uart(input logic [CMD_W-1:0] w);
        @(negedge clk); bus.uart_cmd = w; bus.uart_rdy = 1'b1; #1;
        vectors++; if (bus.uart_clr !== 1'b1) begin miscompares++; $display("FAIL push_uart_clr: got %b want 1", bus.uart_clr); end
        sb.push_back(w);
        @(negedge clk); bus.uart_rdy = 1'b0; #1;
        vectors++; if (bus.uart_clr !== 1'b0) begin miscompares++; $display("FAIL push_uart_clr_width: got %b want 0", bus.uart_clr); end
    endtask

    // Pops one word (leaves clr_cmd_rdy high; caller lowers it).
    task automatic pop_one(input string tag);
        @(negedge clk); bus.clr_cmd_rdy = 1'b1; #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++; $display("FAIL %s_pop: got cmd %h want scoreboard entry (none queued)", tag, bus.cmd);
        end else begin
            exp_w = sb.pop_front();
            if (bus.cmd !== exp_w || bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL %s_pop: got cmd %h rdy %b want %h rdy 1", tag, bus.cmd, bus.cmd_rdy, exp_w); end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.count !== 3'd0 || bus.full !== 1'b0 || bus.stall !== 1'b0 || bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_status: got count %0d full %b stall %b rdy %b want 0 0 0 0", bus.count, bus.full, bus.stall, bus.cmd_rdy); end
        vectors++; if (bus.uart_clr !== 1'b0 || bus.aux_ack !== 1'b0 || bus.cmd !== 16'h0000) begin miscompares++; $display("FAIL reset_outputs: got clr %b ack %b cmd %h want 0 0 0000", bus.uart_clr, bus.aux_ack, bus.cmd); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_u;
        logic [5:0] exp_a;
        exp_u = 6'b000101;
        exp_a = 6'b001010;
        bus.uart_cmd = 16'h1111; bus.aux_cmd = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.uart_rdy = 1'b1; bus.aux_vld = 1'b1; #1;
            vectors++; if (bus.uart_clr !== exp_u[i] || bus.aux_ack !== exp_a[i]) begin miscompares++; $display("FAIL rr_grant[%0d]: got clr %b ack %b want %b %b", i, bus.uart_clr, bus.aux_ack, exp_u[i], exp_a[i]); end
            if (exp_u[i]) sb.push_back(16'h1111);
            if (exp_a[i]) sb.push_back(16'h2222);
            if (i >= 4) begin
                vectors++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin miscompares++; $display("FAIL rr_full[%0d]: got full %b count %0d want 1 4", i, bus.full, bus.count); end
            end
        end
        @(negedge clk); bus.uart_rdy = 1'b0; bus.aux_vld = 1'b0;
        for (int i = 0; i < 4; i++) pop_one("rr");
        @(negedge clk); bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd0 || bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL rr_drain: got count %0d rdy %b want 0 0", bus.count, bus.cmd_rdy); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) push_uart(16'h3000 + 16'(i));
        @(negedge clk); bus.aux_cmd = 16'hABCD; bus.aux_vld = 1'b1; bus.clr_cmd_rdy = 1'b1; #1;
        vectors++; if (bus.aux_ack !== 1'b1 || bus.full !== 1'b1) begin miscompares++; $display("FAIL fullpop_ack: got ack %b full %b want 1 1", bus.aux_ack, bus.full); end
        exp_w = sb.pop_front();
        vectors++; if (bus.cmd !== exp_w) begin miscompares++; $display("FAIL fullpop_head: got %h want %h", bus.cmd, exp_w); end
        sb.push_back(16'hABCD);
        @(negedge clk); bus.aux_vld = 1'b0; bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd4 || bus.aux_ack !== 1'b0) begin miscompares++; $display("FAIL fullpop_count: got count %0d ack %b want 4 0", bus.count, bus.aux_ack); end
        for (int i = 0; i < 4; i++) pop_one("fullpop");
        @(negedge clk); bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL fullpop_drain: got count %0d want 0", bus.count); end
    endtask

    task automatic test_single_uart();
        @(negedge clk); bus.uart_cmd = 16'h00E7; bus.uart_rdy = 1'b1; #1;
        vectors++; if (bus.uart_clr !== 1'b1 || bus.aux_ack !== 1'b0) begin miscompares++; $display("FAIL single_clr: got clr %b ack %b want 1 0", bus.uart_clr, bus.aux_ack); end
        sb.push_back(16'h00E7);
        // Wrapper still holding ready for one cycle: must be masked.
        @(negedge clk); #1;
        vectors++; if (bus.uart_clr !== 1'b0) begin miscompares++; $display("FAIL single_mask: got clr %b want 0", bus.uart_clr); end
        vectors++; if (bus.count !== 3'd1 || bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h00E7) begin miscompares++; $display("FAIL single_head: got count %0d rdy %b cmd %h want 1 1 00e7", bus.count, bus.cmd_rdy, bus.cmd); end
        @(negedge clk); bus.uart_rdy = 1'b0;
        pop_one("single");
        @(negedge clk); bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd0 || bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL single_pop: got count %0d rdy %b want 0 0", bus.count, bus.cmd_rdy); end
    endtask

    task automatic test_empty_flush();
        @(negedge clk); bus.clr_cmd_rdy = 1'b1;
        @(negedge clk); bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd0 || bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL empty_pop: got count %0d rdy %b want 0 0", bus.count, bus.cmd_rdy); end
        for (int i = 0; i < 3; i++) push_uart(16'h4000 + 16'(i));
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL flush_pre: got count %0d want 3", bus.count); end
        @(negedge clk); bus.flush = 1'b1; bus.clr_cmd_rdy = 1'b1; bus.uart_cmd = 16'h4444; bus.uart_rdy = 1'b1; #1;
        vectors++; if (bus.uart_clr !== 1'b0 || bus.aux_ack !== 1'b0) begin miscompares++; $display("FAIL flush_grant: got clr %b ack %b want 0 0", bus.uart_clr, bus.aux_ack); end
        @(negedge clk); bus.flush = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.uart_rdy = 1'b0; #1;
        vectors++; if (bus.count !== 3'd0 || bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL flush_count: got count %0d rdy %b want 0 0", bus.count, bus.cmd_rdy); end
        sb.delete();
    endtask

    task automatic test_watchdog();
        push_uart(16'h5A5A);
        repeat (4096) @(negedge clk);
        #1;
        vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL wd_early: got stall %b want 0", bus.stall); end
        @(negedge clk); #1;
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL wd_fire: got stall %b want 1", bus.stall); end
        pop_one("wd");
        @(negedge clk); bus.clr_cmd_rdy = 1'b0; #1;
        vectors++; if (bus.stall !== 1'b1 || bus.count !== 3'd0) begin miscompares++; $display("FAIL wd_sticky: got stall %b count %0d want 1 0", bus.stall, bus.count); end
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0; #1;
        vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL wd_flush: got stall %b want 0", bus.stall); end
    endtask

    task automatic test_async_reset();
        push_uart(16'h6001);
        push_uart(16'h6002);
        @(negedge clk); bus.aux_cmd = 16'h7777; bus.aux_vld = 1'b1; #1;
        rst = 1'b1; #1;
        vectors++; if (bus.count !== 3'd0 || bus.cmd_rdy !== 1'b0 || bus.aux_ack !== 1'b0 || bus.stall !== 1'b0) begin miscompares++; $display("FAIL arst_status: got count %0d rdy %b ack %b stall %b want 0 0 0 0", bus.count, bus.cmd_rdy, bus.aux_ack, bus.stall); end
        sb.delete();
        @(negedge clk); rst = 1'b0; bus.uart_cmd = 16'h8888; bus.uart_rdy = 1'b1; #1;
        vectors++; if (bus.uart_clr !== 1'b1 || bus.aux_ack !== 1'b0) begin miscompares++; $display("FAIL arst_tie: got clr %b ack %b want 1 0", bus.uart_clr, bus.aux_ack); end
        sb.push_back(16'h8888);
        @(negedge clk); bus.uart_rdy = 1'b0; #1;
        vectors++; if (bus.aux_ack !== 1'b1 || bus.uart_clr !== 1'b0) begin miscompares++; $display("FAIL arst_aux: got ack %b clr %b want 1 0", bus.aux_ack, bus.uart_clr); end
        sb.push_back(16'h7777);
        @(negedge clk); bus.aux_vld = 1'b0; #1;
        vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL arst_refill: got count %0d want 2", bus.count); end
        pop_one("arst");
        pop_one("arst");
        @(negedge clk); bus.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        bus.uart_cmd = 16'h0000; bus.uart_rdy = 1'b0;
        bus.aux_cmd = 16'h0000; bus.aux_vld = 1'b0;
        bus.clr_cmd_rdy = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_round_robin();
        test_full_pop();
        test_single_uart();
        test_empty_flush();
        test_watchdog();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_sched.md
Name: cmd_sched

Overview:
- Command scheduler between the command sources and the command processor.
- Arbitrates two 16-bit command sources into a DEPTH-entry FIFO:
  - the BLE UART wrapper
  - an auxiliary source (on-board route preset / debug port)
- Presents the FIFO head to the command processor through the same cmd/cmd_rdy/clr_cmd_rdy handshake the UART wrapper uses, so queued routes can be run back-to-back.
- Also provides a consumer-stall watchdog.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- FAST_SIM, 1, selects the stall-watchdog threshold: 2^12 cycles when 1, 2^22 cycles when 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- uart_cmd  in  16  command word from UART wrapper
- uart_rdy  in  1  UART command valid; level, held until cleared
- uart_clr  out  1  one-cycle pulse that clears the UART wrapper's ready (its clr_cmd_rdy)
- aux_cmd  in  16  auxiliary command word
- aux_vld  in  1  auxiliary valid; held until aux_ack
- aux_ack  out  1  one-cycle accept pulse for aux
- cmd  out  16  FIFO head word to command processor
- cmd_rdy  out  1  FIFO non-empty
- clr_cmd_rdy  in  1  consumer pop strobe
- flush  in  1  synchronous clear of FIFO and watchdog
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- stall  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1) values:
  - count=0, full=0, stall=0, cmd_rdy=0
  - uart_clr=0, aux_ack=0
  - cmd=16'h0000
  - last-grant flop = SRC_AUX, so UART wins the first tie
  - FSM = IDLE
- Reset mid-operation discards all entries; inputs do not need to be re-presented by the scheduler.
- Arbitration (every cycle):
  - req_u = uart_rdy & ~uart_clr_q, where uart_clr_q is uart_clr registered one cycle. This masks the cycle in which the wrapper is still clearing its ready.
  - req_a = aux_vld & ~aux_ack_q, same masking.
  - Space is available when ~full, or when full and clr_cmd_rdy is popping this cycle.
  - If space is available, grant one requester:
    - only one requesting: grant it
    - both requesting: grant the one not granted last (round-robin)
  - Granting updates the last-grant flop.
  - At most one push per cycle.
- Push timing:
  - The granted word is written at the clock edge.
  - uart_clr or aux_ack is asserted combinationally in the grant cycle and is exactly one cycle wide.
  - The word is visible on cmd no earlier than the next cycle (1-cycle latency into an empty FIFO).
- Output and pop:
  - cmd is the head entry, read combinationally from the registered array; cmd_rdy = (count != 0).
  - clr_cmd_rdy with count=0 is ignored: no pointer move, count stays 0.
  - Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at full and at count=1.
  - Push into empty with no pop: count becomes 1.
- Pointers:
  - Width $clog2(DEPTH); wrap modulo DEPTH.
  - count is tracked separately and never exceeds DEPTH or goes below 0.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: pointers=0, count=0.
  - No grant, uart_clr or aux_ack is issued in a flush cycle.
  - Clears the stall flag and the watchdog.
- Watchdog FSM, states IDLE, WAIT, STALLED:
  - IDLE: when cmd_rdy=1, clear the timer and go to WAIT.
  - WAIT: timer increments each cycle.
    - clr_cmd_rdy pop: go to IDLE if the FIFO becomes empty; otherwise restart the timer and stay in WAIT.
    - Timer reaches threshold with no pop: go to STALLED and set stall=1.
  - STALLED: stall stays set; pushes and pops continue normally.
    - On a pop, return to WAIT with the timer cleared; stall stays set.
  - stall is cleared only by flush or rst.
- Timer width is 22 bits; no wrap is possible before the threshold.

Decomposition:
- Package cmd_sched_pkg holds:
  - CMD_W=16
  - typedef enum logic {SRC_UART, SRC_AUX} src_t
  - typedef enum logic [1:0] {IDLE, WAIT, STALLED} wd_state_t
  - watchdog threshold constants STALL_FAST and STALL_SLOW
- One sub-module, cmd_fifo:
  - Parameterised DEPTH register-array FIFO with push, pop, flush, count, full, empty.
- cmd_sched contains the arbiter, the handshake pulse logic and the watchdog FSM.

Test Plan:
- Single UART push: uart_rdy=1 with uart_cmd=16'h00E7 into empty FIFO → uart_clr pulses for 1 cycle; next cycle cmd=16'h00E7, cmd_rdy=1, count=1. Pop → count=0, cmd_rdy=0.
- Round-robin tie: uart_rdy and aux_vld both held with words 16'h1111 and 16'h2222, no pops → grants go U, A, U, A. After 4 pushes full=1, then no further uart_clr or aux_ack. Pops return 1111, 2222, 1111, 2222 in order.
- Full with simultaneous pop: FIFO full and aux_vld=1 with 16'hABCD, clr_cmd_rdy=1 → aux_ack pulses; count stays 4; the oldest word leaves and ABCD becomes the tail. Checks pointer wrap past DEPTH-1.
- Empty pop and flush precedence: clr_cmd_rdy on empty → count stays 0. With count=3, flush, clr_cmd_rdy and uart_rdy all in one cycle → next cycle count=0, and no uart_clr in that cycle.
- Watchdog (FAST_SIM=1): push one word and never pop → stall=1 exactly 4096 cycles after entering WAIT. A pop keeps stall at 1; flush clears it.
- Async reset mid-operation: rst asserted with count=2 and a pending aux_vld → immediately count=0, cmd_rdy=0, aux_ack=0, stall=0. After release, a simultaneous tie grants UART first.
